jtag_debug_cmd_bridge: RTL

- Parametrised system-clock-side command bridge for the on-chip debug module.
- Accepts level-type update-DR/update-IR strobes and the captured IR/DR contents from the JTAG (TCK) domain, and synchronises the strobes into clk.
- Buffers each completed DR scan as a command in a FIFO and presents it to the debug core over a valid/ready handshake.
- Generalises the fixed 2-bit-IR / 38-bit-DR single-shot decoder to arbitrary IR/DR widths, adds queueing, overflow reporting and a post-reset arming window.

---
 rtl/jtag_debug_cmd_bridge_if.sv | 23 ++
 rtl/jtag_debug_cmd_bridge.sv | 111 +++++++++++
 2 files changed

// File: rtl/jtag_debug_cmd_bridge_if.sv
// Command handshake between the JTAG debug bridge (master) and the debug core (slave).
// The head-of-queue command is qualified by cmd_valid and consumed on cmd_valid & cmd_ready.
`timescale 1ns/1ps
interface jtag_debug_cmd_bridge_if #(
   parameter int IR_W = 2,
   parameter int DR_W = 38
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [IR_W-1:0] cmd_ir;
   logic            cmd_action;
   logic [DR_W-1:0] cmd_data;

   modport master (
      output cmd_valid, cmd_ir, cmd_action, cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_ir, cmd_action, cmd_data,
      output cmd_ready
   );
endinterface

// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock side of the debug JTAG bridge: synchronises update-DR/IR strobes,
// queues each completed DR scan in a FIFO and presents it over a valid/ready handshake.
`timescale 1ns/1ps
module jtag_debug_cmd_bridge #(
   parameter int IR_W        = 2,
   parameter int DR_W        = 38,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               vs_udr,
   input  logic                               vs_uir,
   input  logic [IR_W-1:0]                    ir_in,
   input  logic [DR_W-1:0]                    sr,
   jtag_debug_cmd_bridge_if.master            cmd,
   output logic                               ir_update,
   output logic                               overflow,
   input  logic                               clr_overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PW    = AW + 1;
   localparam int LW    = $clog2(FIFO_DEPTH + 1);
   localparam int ARM_W = $clog2(SYNC_STAGES + 2);

   typedef struct packed {
      logic [IR_W-1:0] ir;
      logic            action;
      logic [DR_W-1:0] data;
   } cmd_t;

   logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
   logic                   udr_dly_q, uir_dly_q;
   logic [ARM_W-1:0]       arm_q;
   logic [PW-1:0]          wptr_q, rptr_q;
   logic [PW-1:0]          wptr_d, rptr_d;
   cmd_t                   head_q;
   logic                   valid_q, valid_d;
   logic                   ir_update_q;
   logic                   overflow_q;
   cmd_t                   mem_q [FIFO_DEPTH];

   logic armed, udr_edge, uir_edge, full, pop, push, drop;

   // Edges are masked until the sync chain has flushed whatever level was present at reset release.
   assign armed    = (arm_q == '0);
   assign udr_edge = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q & armed;
   assign uir_edge = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q & armed;

   assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop  = valid_q & cmd.cmd_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push = udr_edge & (~full | pop);
   assign drop = udr_edge & full & ~pop;

   assign rptr_d  = rptr_q + PW'(pop);
   assign wptr_d  = wptr_q + PW'(push);
   // The head register sees only entries written before this edge, adding one cycle of latency.
   assign valid_d = (rptr_d != wptr_q);

   always_ff @(posedge clk) begin
      // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         udr_sync_q  <= '0;
         uir_sync_q  <= '0;
         udr_dly_q   <= 1'b0;
         uir_dly_q   <= 1'b0;
         arm_q       <= ARM_W'(SYNC_STAGES + 1);
         wptr_q      <= '0;
         rptr_q      <= '0;
         head_q      <= '0;
         valid_q     <= 1'b0;
         ir_update_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
         uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
         udr_dly_q   <= udr_sync_q[SYNC_STAGES-1];
         uir_dly_q   <= uir_sync_q[SYNC_STAGES-1];
         if (arm_q != '0) begin
            arm_q <= arm_q - 1'b1;
         end
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         valid_q     <= valid_d;
         if (valid_d) begin
            head_q <= mem_q[rptr_d[AW-1:0]];
         end
         ir_update_q <= uir_edge;
         overflow_q  <= drop | (overflow_q & ~clr_overflow);
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= '{ir: ir_in, action: sr[DR_W-1], data: sr};
      end
   end

   assign cmd.cmd_valid  = valid_q;
   assign cmd.cmd_ir     = head_q.ir;
   assign cmd.cmd_action = head_q.action;
   assign cmd.cmd_data   = head_q.data;
   assign ir_update      = ir_update_q;
   assign overflow       = overflow_q;
   assign fifo_level     = LW'(wptr_q - rptr_q);

endmodule
